hyperbus_target: RTL and testbench
==================================

// Module: hyperbus_target
// PURPOSE
//  HyperBus secondary (HyperRAM-style responder) for FPGA loopback and controller bring-up.
//  Oversamples the bus CK/CS#/DQ/RWDS on a fast system clock (>=4x CK).
//  Decodes the 48-bit command/address, applies initial latency and serves linear/wrapped
//  reads and masked writes from an internal RAM and a small register space (ID0, ID1, CR0).
// PARAMETERS
//  DEPTH_LOG2   10        internal RAM depth in 16-bit words (2**DEPTH_LOG2)
//  TACC_COUNT   5         initial latency in CK cycles (1x); doubled when 2x latency is active
//  SYNC_STAGES  2         synchronizer flops on every bus input (>=2)
//  ID0_VAL      16'h0C81  register word address 0x000 read value
//  ID1_VAL      16'h0001  register word address 0x001 read value
//  CR0_RESET    16'h8F1F  CR0 (word address 0x800) reset value; CR0[3]=1 selects fixed 2x latency
// PORTS
//  clk          in   1   system clock, >=4x hbus_ck frequency
//  rstn         in   1   asynchronous active-low reset
//  hbus_ck      in   1   bus clock from the controller
//  hbus_csn     in   1   bus chip select, active low
//  hbus_rstn    in   1   bus device reset, active low
//  hbus_dq_i    in   8   DQ sampled from the pad
//  hbus_dq_o    out  8   DQ drive value
//  hbus_dq_oe   out  1   DQ output enable
//  hbus_rwds_i  in   1   RWDS sampled from the pad (write mask)
//  hbus_rwds_o  out  1   RWDS drive value (latency indicator / read strobe)
//  hbus_rwds_oe out  1   RWDS output enable
//  cr0_o        out  16  current CR0 value
//  active_o     out  1   transaction in progress (state != IDLE)
//  err_o        out  1   sticky protocol error
// BEHAVIOUR
//  Reset (rstn low, async): all outputs 0 except cr0_o=CR0_RESET; state IDLE. RAM contents are undefined.
//  Sync: inputs pass SYNC_STAGES flops. A "ck event" is either edge of synced ck.
//   DQ/RWDS are sampled from the same synced stage as ck. Outputs update 1 clk after the event.
//  Synced hbus_rstn low: state IDLE, all oe 0, cr0_o=CR0_RESET, err_o cleared. RAM retained.
//  lat2x = cr0_o[3]. States:
//   IDLE: all oe 0. Synced csn falling -> CA; edge count=0; rwds_oe=1; rwds_o=lat2x.
//   CA: each ck event shifts one byte into ca[47:0], MSB first. After the 6th event:
//    rwds_oe=0; decode rw=ca[47], as=ca[46], linear=ca[45], waddr={ca[44:16],ca[2:0]}.
//    If as=1 and rw=0 -> WDATA (register write, zero latency).
//    Otherwise -> LATENCY with lcnt = 2*TACC_COUNT*(lat2x?2:1) ck events.
//   LATENCY: decrement lcnt per ck event. At 0 -> RDATA if rw=1, else WDATA.
//    On entry to RDATA, fetch word 0; the RAM has 1-clk read latency and the data is ready before the next event.
//   RDATA: dq_oe=rwds_oe=1. Even event: dq_o=word[15:8], rwds_o=1.
//    Odd event: dq_o=word[7:0], rwds_o=0; advance waddr and prefetch.
//   WDATA: even event: capture high byte and mask (rwds_i=1 -> byte masked).
//    Odd event: capture low byte; write word with per-byte enables; advance waddr.
//    Register write at 0x800 updates cr0_o; other register writes are ignored.
//  Address advance: linear -> +1 modulo 2**DEPTH_LOG2.
//   Wrapped (linear=0) -> increment waddr[3:0] only (16-word wrap).
//  Register reads: 0x000 ID0_VAL, 0x001 ID1_VAL, 0x800 cr0_o, else 16'h0000. Register reads still use latency.
//  RAM index = waddr[DEPTH_LOG2-1:0]; upper bits are ignored (aliasing).
//  Synced csn rising, in any state: next clk all oe 0, state IDLE.
//   A half-captured write word (high byte only) is discarded.
//   err_o set if csn rises in CA or LATENCY; cleared only by rstn or hbus_rstn.
//  csn falling while not IDLE cannot occur (csn must rise first).
// TESTING
//  1. Reset: rstn low -> all oe 0, cr0_o=16'h8F1F, err_o=0, active_o=0.
//  2. Linear write: write 0x0010, 4 words A5A5,1234,BEEF,0F0F with no mask; then read back.
//     -> rwds_o=1 during CA; 20 ck latency; readback byte stream A5,A5,12,34,BE,EF,0F,0F with RWDS toggling 1/0.
//  3. Masked write: write 0x0020=FFFF, then write 0x0020=0000 with high byte masked -> read returns FF00.
//  4. Wrapped read: 16-word burst starting 0x003E, 3 words -> words 0x3E, 0x3F, 0x30.
//  5. Register write: CR0=0x8F17 (zero latency), then next transaction -> rwds_o=0 in CA, latency 10 ck events.
//     Read register 0x000 -> 0C81.
//  6. Abort: csn rises after 3 CA bytes -> err_o=1, oe 0, IDLE.
//     Abort mid-word in WDATA -> word unchanged, err_o unchanged.

Source files
------------

// File: rtl/hyperbus_target.sv
// hyperbus_target: HyperBus responder (HyperRAM-style) for loopback and controller bring-up.
// Every bus input is synchronized onto the fast system clock. Both edges of the synced bus
// clock are treated as "ck events" that step the transaction FSM. The target serves
// linear or 16-word-wrapped bursts from an internal RAM, and from a small register space
// holding ID0, ID1 and CR0.
// Framing: a transaction runs from a synced csn falling edge to a synced csn rising edge.
// Data bytes move only on ck events, high byte first. A rising csn ends the transaction
// unconditionally on the next clk, and this takes priority over any ck event seen in
// the same clk.
module hyperbus_target #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          TACC_COUNT  = 5,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID0_VAL     = 16'h0C81,
  parameter logic [15:0] ID1_VAL     = 16'h0001,
  parameter logic [15:0] CR0_RESET   = 16'h8F1F
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hbus_ck,
  input  logic        hbus_csn,
  input  logic        hbus_rstn,
  input  logic [7:0]  hbus_dq_i,
  output logic [7:0]  hbus_dq_o,
  output logic        hbus_dq_oe,
  input  logic        hbus_rwds_i,
  output logic        hbus_rwds_o,
  output logic        hbus_rwds_oe,
  output logic [15:0] cr0_o,
  output logic        active_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int LCNT_W = $clog2(4 * TACC_COUNT + 1);
  localparam logic [LCNT_W-1:0] LAT_1X = LCNT_W'(2 * TACC_COUNT);
  localparam logic [LCNT_W-1:0] LAT_2X = LCNT_W'(4 * TACC_COUNT);
  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_ID1 = 32'h0000_0001;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;
  // Bit order: {rstn, rwds, dq[7:0], csn, ck}. The reset value keeps csn high, so no
  // spurious transaction start is seen when reset is released.
  localparam logic [11:0] SYNC_RST = 12'h002;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CA      = 3'd1,
    S_LATENCY = 3'd2,
    S_RDATA   = 3'd3,
    S_WDATA   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Synchronizer chain and edge-detect history.
  logic [11:0] bus_in;
  logic [11:0] sync_q [SYNC_STAGES];
  logic        ck_d, csn_d;
  logic        ck_s, csn_s, rstn_s, rwds_s;
  logic [7:0]  dq_s;
  logic        ck_ev, csn_fall, csn_rise;

  // Transaction context.
  logic [39:0]       ca_q, ca_nxt;
  logic [47:0]       ca_full;
  logic [2:0]        bcnt_q, bcnt_nxt;
  logic              rw_q, rw_nxt;
  logic              as_q, as_nxt;
  logic              lin_q, lin_nxt;
  logic [31:0]       waddr_q, waddr_nxt, waddr_inc;
  logic [LCNT_W-1:0] lcnt_q, lcnt_nxt;
  logic              phase_q, phase_nxt;
  logic [7:0]        whi_q, whi_nxt;
  logic              mhi_q, mhi_nxt;

  // Output registers.
  logic [7:0]  dq_o_q, dq_o_nxt;
  logic        dq_oe_q, dq_oe_nxt;
  logic        rwds_o_q, rwds_o_nxt;
  logic        rwds_oe_q, rwds_oe_nxt;
  logic [15:0] cr0_q, cr0_nxt;
  logic        err_q, err_nxt;

  // Memory and read-data path.
  logic [15:0] mem [DEPTH];
  logic [15:0] ram_q;
  logic [15:0] reg_rdata, rd_word;
  logic        mem_we_hi, mem_we_lo;
  logic [15:0] mem_wdata;
  logic        lat2x;

  assign bus_in   = {hbus_rstn, hbus_rwds_i, hbus_dq_i, hbus_csn, hbus_ck};
  assign ck_s     = sync_q[SYNC_STAGES-1][0];
  assign csn_s    = sync_q[SYNC_STAGES-1][1];
  assign dq_s     = sync_q[SYNC_STAGES-1][9:2];
  assign rwds_s   = sync_q[SYNC_STAGES-1][10];
  assign rstn_s   = sync_q[SYNC_STAGES-1][11];
  assign ck_ev    = ck_s ^ ck_d;
  assign csn_fall = ~csn_s & csn_d;
  assign csn_rise = csn_s & ~csn_d;
  assign ca_full  = {ca_q, dq_s};
  assign lat2x    = cr0_q[3];

  // Bring all bus inputs through the synchronizer chain and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      ck_d  <= 1'b0;
      csn_d <= 1'b1;
    end else begin
      sync_q[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ck_d  <= ck_s;
      csn_d <= csn_s;
    end
  end

  // Next burst address: a linear burst wraps at the RAM size, a wrapped burst stays inside its 16-word block.
  always_comb begin
    waddr_inc = waddr_q;
    if (lin_q) waddr_inc[DEPTH_LOG2-1:0] = waddr_q[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
    else       waddr_inc[3:0]            = waddr_q[3:0] + 4'd1;
  end

  // Register-space read mux. The read word comes from here or from the RAM, depending on the address space.
  always_comb begin
    reg_rdata = 16'h0000;
    case (waddr_q)
      REG_ID0: reg_rdata = ID0_VAL;
      REG_ID1: reg_rdata = ID1_VAL;
      REG_CR0: reg_rdata = cr0_q;
      default: reg_rdata = 16'h0000;
    endcase
    rd_word = as_q ? reg_rdata : ram_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath logic. Bus reset takes priority over csn rising, and csn rising takes priority over ck events.
  always_comb begin
    state_nxt   = state;
    ca_nxt      = ca_q;
    bcnt_nxt    = bcnt_q;
    rw_nxt      = rw_q;
    as_nxt      = as_q;
    lin_nxt     = lin_q;
    waddr_nxt   = waddr_q;
    lcnt_nxt    = lcnt_q;
    phase_nxt   = phase_q;
    whi_nxt     = whi_q;
    mhi_nxt     = mhi_q;
    dq_o_nxt    = dq_o_q;
    dq_oe_nxt   = dq_oe_q;
    rwds_o_nxt  = rwds_o_q;
    rwds_oe_nxt = rwds_oe_q;
    cr0_nxt     = cr0_q;
    err_nxt     = err_q;
    mem_we_hi   = 1'b0;
    mem_we_lo   = 1'b0;
    mem_wdata   = {whi_q, dq_s};
    if (!rstn_s) begin
      state_nxt   = S_IDLE;
      dq_o_nxt    = 8'h00;
      dq_oe_nxt   = 1'b0;
      rwds_o_nxt  = 1'b0;
      rwds_oe_nxt = 1'b0;
      cr0_nxt     = CR0_RESET;
      err_nxt     = 1'b0;
    end else if (csn_rise) begin
      state_nxt   = S_IDLE;
      dq_oe_nxt   = 1'b0;
      rwds_oe_nxt = 1'b0;
      if (state == S_CA || state == S_LATENCY) err_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          dq_oe_nxt   = 1'b0;
          rwds_oe_nxt = 1'b0;
          if (csn_fall) begin
            state_nxt   = S_CA;
            bcnt_nxt    = 3'd0;
            rwds_oe_nxt = 1'b1;
            rwds_o_nxt  = lat2x;
          end
        end
        S_CA: begin
          if (ck_ev) begin
            ca_nxt   = ca_full[39:0];
            bcnt_nxt = bcnt_q + 3'd1;
            if (bcnt_q == 3'd5) begin
              rwds_oe_nxt = 1'b0;
              rwds_o_nxt  = 1'b0;
              rw_nxt      = ca_full[47];
              as_nxt      = ca_full[46];
              lin_nxt     = ca_full[45];
              waddr_nxt   = {ca_full[44:16], ca_full[2:0]};
              phase_nxt   = 1'b0;
              lcnt_nxt    = lat2x ? LAT_2X : LAT_1X;
              // Register writes have zero latency; all other commands wait out the latency.
              if (ca_full[46] && !ca_full[47]) state_nxt = S_WDATA;
              else                             state_nxt = S_LATENCY;
            end
          end
        end
        S_LATENCY: begin
          if (ck_ev) begin
            if (lcnt_q <= LCNT_W'(1)) begin
              lcnt_nxt  = '0;
              phase_nxt = 1'b0;
              if (rw_q) begin
                state_nxt   = S_RDATA;
                dq_oe_nxt   = 1'b1;
                rwds_oe_nxt = 1'b1;
                rwds_o_nxt  = 1'b0;
              end else begin
                state_nxt = S_WDATA;
              end
            end else begin
              lcnt_nxt = lcnt_q - LCNT_W'(1);
            end
          end
        end
        S_RDATA: begin
          dq_oe_nxt   = 1'b1;
          rwds_oe_nxt = 1'b1;
          if (ck_ev) begin
            if (!phase_q) begin
              dq_o_nxt   = rd_word[15:8];
              rwds_o_nxt = 1'b1;
              phase_nxt  = 1'b1;
            end else begin
              dq_o_nxt   = rd_word[7:0];
              rwds_o_nxt = 1'b0;
              phase_nxt  = 1'b0;
              waddr_nxt  = waddr_inc;
            end
          end
        end
        S_WDATA: begin
          if (ck_ev) begin
            if (!phase_q) begin
              whi_nxt   = dq_s;
              mhi_nxt   = rwds_s;
              phase_nxt = 1'b1;
            end else begin
              phase_nxt = 1'b0;
              waddr_nxt = waddr_inc;
              if (as_q) begin
                if (waddr_q == REG_CR0)
                  cr0_nxt = {mhi_q ? cr0_q[15:8] : whi_q, rwds_s ? cr0_q[7:0] : dq_s};
              end else begin
                mem_we_hi = ~mhi_q;
                mem_we_lo = ~rwds_s;
              end
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ca_q      <= '0;
      bcnt_q    <= 3'd0;
      rw_q      <= 1'b0;
      as_q      <= 1'b0;
      lin_q     <= 1'b0;
      waddr_q   <= '0;
      lcnt_q    <= '0;
      phase_q   <= 1'b0;
      whi_q     <= 8'h00;
      mhi_q     <= 1'b0;
      dq_o_q    <= 8'h00;
      dq_oe_q   <= 1'b0;
      rwds_o_q  <= 1'b0;
      rwds_oe_q <= 1'b0;
      cr0_q     <= CR0_RESET;
      err_q     <= 1'b0;
    end else begin
      ca_q      <= ca_nxt;
      bcnt_q    <= bcnt_nxt;
      rw_q      <= rw_nxt;
      as_q      <= as_nxt;
      lin_q     <= lin_nxt;
      waddr_q   <= waddr_nxt;
      lcnt_q    <= lcnt_nxt;
      phase_q   <= phase_nxt;
      whi_q     <= whi_nxt;
      mhi_q     <= mhi_nxt;
      dq_o_q    <= dq_o_nxt;
      dq_oe_q   <= dq_oe_nxt;
      rwds_o_q  <= rwds_o_nxt;
      rwds_oe_q <= rwds_oe_nxt;
      cr0_q     <= cr0_nxt;
      err_q     <= err_nxt;
    end
  end

  // RAM with per-byte write enables. It has a registered read of the current burst word,
  // which always settles well before the next ck event.
  always_ff @(posedge clk) begin
    if (mem_we_hi) mem[waddr_q[DEPTH_LOG2-1:0]][15:8] <= mem_wdata[15:8];
    if (mem_we_lo) mem[waddr_q[DEPTH_LOG2-1:0]][7:0]  <= mem_wdata[7:0];
    ram_q <= mem[waddr_q[DEPTH_LOG2-1:0]];
  end

  assign hbus_dq_o    = dq_o_q;
  assign hbus_dq_oe   = dq_oe_q;
  assign hbus_rwds_o  = rwds_o_q;
  assign hbus_rwds_oe = rwds_oe_q;
  assign cr0_o        = cr0_q;
  assign err_o        = err_q;
  assign active_o     = (state != S_IDLE);
  assign state_o      = state;

endmodule

// File: tb/tb_hyperbus_target.sv
// tb_hyperbus_target: directed bench for hyperbus_target. The bus clock runs at 1/8 of clk.
// DQ and RWDS change together with each ck edge, and outputs are sampled on clk falling edges.
module tb_hyperbus_target;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hbus_ck, hbus_csn, hbus_rstn;
  logic [7:0]  hbus_dq_i;
  logic [7:0]  hbus_dq_o;
  logic        hbus_dq_oe;
  logic        hbus_rwds_i, hbus_rwds_o, hbus_rwds_oe;
  logic [15:0] cr0_o;
  logic        active_o, err_o;
  logic [2:0]  state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cr0_exp;
  logic [15:0] exp_q[$];
  logic [17:0] wr_q[$];

  hyperbus_target dut (
    .clk(clk), .rstn(rstn), .hbus_ck(hbus_ck), .hbus_csn(hbus_csn), .hbus_rstn(hbus_rstn),
    .hbus_dq_i(hbus_dq_i), .hbus_dq_o(hbus_dq_o), .hbus_dq_oe(hbus_dq_oe),
    .hbus_rwds_i(hbus_rwds_i), .hbus_rwds_o(hbus_rwds_o), .hbus_rwds_oe(hbus_rwds_oe),
    .cr0_o(cr0_o), .active_o(active_o), .err_o(err_o), .state_o(state_o)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ck_edge(input logic [7:0] d, input logic m);
    hbus_dq_i   = d;
    hbus_rwds_i = m;
    hbus_ck     = ~hbus_ck;
    wait_clks(4);
  endtask

  task automatic cs_low();
    hbus_csn = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_high();
    hbus_csn = 1'b1;
    wait_clks(4);
    if (hbus_ck) begin
      hbus_ck = 1'b0;
      wait_clks(4);
    end
  endtask

  function automatic logic [47:0] make_ca(input logic rw, input logic as_, input logic lin,
                                          input logic [31:0] addr);
    logic [47:0] c;
    c        = '0;
    c[47]    = rw;
    c[46]    = as_;
    c[45]    = lin;
    c[44:16] = addr[31:3];
    c[2:0]   = addr[2:0];
    return c;
  endfunction

  task automatic send_ca(input logic [47:0] ca);
    for (int i = 0; i < 6; i++) ck_edge(ca[47-8*i -: 8], 1'b0);
  endtask

  // Write burst. Each wr_q entry is {mask_hi, mask_lo, data}.
  task automatic write_burst(input logic as_, input logic lin, input logic [31:0] addr, input int nw);
    logic [17:0] it;
    int          lat;
    lat = cr0_exp[3] ? 20 : 10;
    cs_low();
    send_ca(make_ca(1'b0, as_, lin, addr));
    if (!as_) for (int i = 0; i < lat; i++) ck_edge(8'h00, 1'b0);
    for (int w = 0; w < nw; w++) begin
      it = wr_q.pop_front();
      ck_edge(it[15:8], it[17]);
      ck_edge(it[7:0], it[16]);
    end
    cs_high();
  endtask

  // Read burst. Checks the CA latency indicator, the latency length and every byte against exp_q.
  task automatic read_burst(input string name, input logic as_, input logic lin,
                            input logic [31:0] addr, input int nw);
    logic [15:0] e;
    int          lat;
    lat = cr0_exp[3] ? 20 : 10;
    cs_low();
    n_checks++;
    if ({hbus_rwds_oe, hbus_rwds_o, active_o} !== {1'b1, cr0_exp[3], 1'b1}) begin
      n_fail++;
      $display("FAIL %s ca_rwds: got oe/rwds/active %b%b%b required %b%b%b", name,
               hbus_rwds_oe, hbus_rwds_o, active_o, 1'b1, cr0_exp[3], 1'b1);
    end
    send_ca(make_ca(1'b1, as_, lin, addr));
    n_checks++;
    if (hbus_rwds_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL %s rwds_oe_after_ca: got %b required 0", name, hbus_rwds_oe);
    end
    for (int i = 1; i <= lat; i++) begin
      ck_edge(8'h00, 1'b0);
      if (i == lat - 1) begin
        n_checks++;
        if (hbus_dq_oe !== 1'b0) begin
          n_fail++;
          $display("FAIL %s latency_early: got dq_oe %b required 0 after %0d events", name, hbus_dq_oe, i);
        end
      end
    end
    n_checks++;
    if ({hbus_dq_oe, hbus_rwds_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s latency_end: got dq_oe/rwds_oe %b%b required 11 after %0d events", name,
               hbus_dq_oe, hbus_rwds_oe, lat);
    end
    for (int w = 0; w < nw; w++) begin
      e = exp_q.pop_front();
      ck_edge(8'h00, 1'b0);
      n_checks++;
      if ({hbus_dq_oe, hbus_rwds_o, hbus_dq_o} !== {1'b1, 1'b1, e[15:8]}) begin
        n_fail++;
        $display("FAIL %s word%0d_hi: got oe=%b rwds=%b dq=%h required oe=1 rwds=1 dq=%h", name, w,
                 hbus_dq_oe, hbus_rwds_o, hbus_dq_o, e[15:8]);
      end
      ck_edge(8'h00, 1'b0);
      n_checks++;
      if ({hbus_dq_oe, hbus_rwds_o, hbus_dq_o} !== {1'b1, 1'b0, e[7:0]}) begin
        n_fail++;
        $display("FAIL %s word%0d_lo: got oe=%b rwds=%b dq=%h required oe=1 rwds=0 dq=%h", name, w,
                 hbus_dq_oe, hbus_rwds_o, hbus_dq_o, e[7:0]);
      end
    end
    cs_high();
    n_checks++;
    if ({hbus_dq_oe, hbus_rwds_oe, active_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s end: got dq_oe/rwds_oe/active %b%b%b required 000", name,
               hbus_dq_oe, hbus_rwds_oe, active_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; hbus_ck = 1'b0; hbus_csn = 1'b1; hbus_rstn = 1'b1;
    hbus_dq_i = 8'h00; hbus_rwds_i = 1'b0;
    cr0_exp = 16'h8F1F;
    wait_clks(3);
    n_checks++;
    if ({hbus_dq_oe, hbus_rwds_oe, hbus_dq_o, hbus_rwds_o} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got dq_oe=%b rwds_oe=%b dq=%h rwds=%b required all 0",
               hbus_dq_oe, hbus_rwds_oe, hbus_dq_o, hbus_rwds_o);
    end
    n_checks++;
    if (cr0_o !== 16'h8F1F) begin
      n_fail++;
      $display("FAIL reset_cr0: got %h required 8f1f", cr0_o);
    end
    n_checks++;
    if ({err_o, active_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_err_active: got %b%b required 00", err_o, active_o);
    end
    rstn = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_linear();
    wr_q.push_back({2'b00, 16'hA5A5}); wr_q.push_back({2'b00, 16'h1234});
    wr_q.push_back({2'b00, 16'hBEEF}); wr_q.push_back({2'b00, 16'h0F0F});
    write_burst(1'b0, 1'b1, 32'h10, 4);
    exp_q.push_back(16'hA5A5); exp_q.push_back(16'h1234);
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'h0F0F);
    read_burst("linear", 1'b0, 1'b1, 32'h10, 4);
  endtask

  task automatic test_masked();
    wr_q.push_back({2'b00, 16'hFFFF});
    write_burst(1'b0, 1'b1, 32'h20, 1);
    wr_q.push_back({2'b10, 16'h0000});
    write_burst(1'b0, 1'b1, 32'h20, 1);
    exp_q.push_back(16'hFF00);
    read_burst("masked", 1'b0, 1'b1, 32'h20, 1);
  endtask

  task automatic test_wrapped();
    wr_q.push_back({2'b00, 16'hC3E0}); wr_q.push_back({2'b00, 16'hC3F1});
    write_burst(1'b0, 1'b1, 32'h3E, 2);
    wr_q.push_back({2'b00, 16'hC300});
    write_burst(1'b0, 1'b1, 32'h30, 1);
    exp_q.push_back(16'hC3E0); exp_q.push_back(16'hC3F1); exp_q.push_back(16'hC300);
    read_burst("wrapped", 1'b0, 1'b0, 32'h3E, 3);
  endtask

  task automatic test_boundary();
    wr_q.push_back({2'b00, 16'h7FF7});
    write_burst(1'b0, 1'b1, 32'h3FF, 1);
    wr_q.push_back({2'b00, 16'hABCD});
    write_burst(1'b0, 1'b1, 32'h400, 1);  // aliases word 0
    exp_q.push_back(16'h7FF7); exp_q.push_back(16'hABCD);
    read_burst("linear_modulo", 1'b0, 1'b1, 32'h3FF, 2);
    exp_q.push_back(16'hABCD);
    read_burst("alias", 1'b0, 1'b1, 32'h000, 1);
  endtask

  task automatic test_register();
    wr_q.push_back({2'b00, 16'h8F17});
    write_burst(1'b1, 1'b1, 32'h800, 1);
    cr0_exp = 16'h8F17;
    n_checks++;
    if (cr0_o !== 16'h8F17) begin
      n_fail++;
      $display("FAIL reg_cr0_write: got %h required 8f17", cr0_o);
    end
    wr_q.push_back({2'b00, 16'h1234});
    write_burst(1'b1, 1'b1, 32'h002, 1);
    n_checks++;
    if (cr0_o !== 16'h8F17) begin
      n_fail++;
      $display("FAIL reg_other_write: got cr0 %h required 8f17", cr0_o);
    end
    exp_q.push_back(16'h0C81); exp_q.push_back(16'h0001);
    read_burst("reg_id", 1'b1, 1'b1, 32'h000, 2);
    exp_q.push_back(16'h8F17);
    read_burst("reg_cr0", 1'b1, 1'b1, 32'h800, 1);
    exp_q.push_back(16'h0000);
    read_burst("reg_unmapped", 1'b1, 1'b1, 32'h005, 1);
    exp_q.push_back(16'hABCD);
    read_burst("ram_after_regwr", 1'b0, 1'b1, 32'h000, 1);
  endtask

  task automatic test_abort_ca();
    cs_low();
    for (int i = 0; i < 3; i++) ck_edge(8'h80, 1'b0);
    cs_high();
    n_checks++;
    if ({err_o, hbus_dq_oe, hbus_rwds_oe, active_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_ca: got err/dq_oe/rwds_oe/active %b%b%b%b required 1000",
               err_o, hbus_dq_oe, hbus_rwds_oe, active_o);
    end
  endtask

  task automatic test_bus_reset();
    hbus_rstn = 1'b0;
    wait_clks(4);
    n_checks++;
    if ({cr0_o, err_o, active_o} !== {16'h8F1F, 2'b00}) begin
      n_fail++;
      $display("FAIL bus_reset: got cr0=%h err=%b active=%b required cr0=8f1f err=0 active=0",
               cr0_o, err_o, active_o);
    end
    hbus_rstn = 1'b1;
    wait_clks(4);
    cr0_exp = 16'h8F1F;
    exp_q.push_back(16'hA5A5);
    read_burst("ram_retained", 1'b0, 1'b1, 32'h10, 1);
  endtask

  task automatic test_abort_wdata();
    cs_low();
    send_ca(make_ca(1'b0, 1'b0, 1'b1, 32'h10));
    for (int i = 0; i < 20; i++) ck_edge(8'h00, 1'b0);
    ck_edge(8'h55, 1'b0);
    cs_high();
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wdata_err: got %b required 0", err_o);
    end
    exp_q.push_back(16'hA5A5);
    read_burst("abort_wdata_word", 1'b0, 1'b1, 32'h10, 1);
    cs_low();
    send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h10));
    for (int i = 0; i < 5; i++) ck_edge(8'h00, 1'b0);
    cs_high();
    n_checks++;
    if ({err_o, active_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_latency: got err/active %b%b required 10", err_o, active_o);
    end
  endtask

  // Test sequence and summary.
  initial begin
    @(negedge clk);
    test_reset();
    test_linear();
    test_masked();
    test_wrapped();
    test_boundary();
    test_register();
    test_abort_ca();
    test_bus_reset();
    test_abort_wdata();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
